// File: rtl/iob_split_bus_bridge_pkg.sv
// Shared definitions for the split-bus to IOb bridge: access size codes,
// FSM state encoding and the byte-offset width helper.
package iob_split_bus_bridge_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   // Number of byte-offset address bits inside one data word (DATA_W is 32 or 64).
   function automatic int off_w(input int data_w);
      return (data_w == 64) ? 3 : 2;
   endfunction

endpackage

// File: rtl/iob_split_bus_bridge_if.sv
// Bundle of the CPU command/response bus and the IOb native bus seen by one bridge.
// slave = bridge view; master = the CPU plus memory environment around it.
interface iob_split_bus_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_wr;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [1:0]            cmd_size;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_error;
   logic                  iob_valid;
   logic [ADDR_W-1:0]     iob_addr;
   logic [DATA_W-1:0]     iob_wdata;
   logic [DATA_W/8-1:0]   iob_wstrb;
   logic [DATA_W-1:0]     iob_rdata;
   logic                  iob_ready;

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_size, iob_rdata, iob_ready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, iob_valid, iob_addr, iob_wdata, iob_wstrb
   );

   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_size, iob_rdata, iob_ready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, iob_valid, iob_addr, iob_wdata, iob_wstrb
   );
endinterface

// File: rtl/iob_split_bus_bridge_strb.sv
// Combinational size/offset decode: byte strobes for writes plus a flag for
// misaligned or oversized accesses.
module iob_split_bus_bridge_strb
   import iob_split_bus_bridge_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8,
   localparam int OFF_W  = off_w(DATA_W)
) (
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [OFF_W-1:0]  addr_lo,
   output logic [STRB_W-1:0] wstrb,
   output logic              illegal
);
   localparam logic [1:0] MAX_SIZE = (OFF_W == 3) ? SIZE_D : SIZE_W;

   logic [4:0]       lo_ext;
   logic [4:0]       nbytes;
   logic [4:0]       hi_ext;
   logic [OFF_W-1:0] align_mask;

   always_comb begin
      nbytes = 5'd8;
      case (size)
         SIZE_B:  nbytes = 5'd1;
         SIZE_H:  nbytes = 5'd2;
         SIZE_W:  nbytes = 5'd4;
         default: nbytes = 5'd8;
      endcase
      lo_ext     = 5'(addr_lo);
      hi_ext     = lo_ext + nbytes;
      align_mask = OFF_W'(nbytes - 5'd1);
      illegal    = (|(addr_lo & align_mask)) | (size > MAX_SIZE);
   end

   // A lane is written when it falls inside [offset, offset + bytes).
   generate
      for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
         assign wstrb[gi] = wr & ~illegal & (lo_ext <= 5'(gi)) & (5'(gi) < hi_ext);
      end
   endgenerate

endmodule

// File: rtl/iob_split_bus_bridge.sv
// CPU split command/response bus to IOb native bus bridge with registered request
// path, misalignment and timeout errors. Optional macro: IOB_SPLIT_BRIDGE_REMAP_EN.
module iob_split_bus_bridge
   import iob_split_bus_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int WR_RSP  = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   boot,
   iob_split_bus_bridge_if.slave  bus
);
   localparam int               STRB_W    = DATA_W / 8;
   localparam int               OFF_W     = off_w(DATA_W);
   localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic             WR_RSP_EN = (WR_RSP != 0);
   localparam logic             TMO_EN    = (TIMEOUT > 0);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                err_pend_q, err_pend_d;

   logic                cmd_ready;
   logic                accept;
   logic                err_rsp_req;
   logic                done;
   logic                done_rsp;
   logic                expire;
   logic [STRB_W-1:0]   cmd_wstrb;
   logic                cmd_illegal;
   logic [ADDR_W-1:0]   addr_map;

   iob_split_bus_bridge_strb #(
      .DATA_W (DATA_W)
   ) u_strb (
      .wr      (bus.cmd_wr),
      .size    (bus.cmd_size),
      .addr_lo (bus.cmd_addr[OFF_W-1:0]),
      .wstrb   (cmd_wstrb),
      .illegal (cmd_illegal)
   );

`ifdef IOB_SPLIT_BRIDGE_REMAP_EN
   assign addr_map = {~boot ^ bus.cmd_addr[ADDR_W-1], bus.cmd_addr[ADDR_W-2:0]};
`else
   logic unused_boot;
   assign unused_boot = boot;
   assign addr_map    = bus.cmd_addr;
`endif

   always_comb begin
      // A deferred error response blocks new commands for one cycle so two
      // responses never compete for the same rsp_valid slot.
      cmd_ready   = ((state_q == ST_IDLE) & ~err_pend_q) | ((state_q == ST_REQ) & bus.iob_ready);
      accept      = bus.cmd_valid & cmd_ready;
      err_rsp_req = ~bus.cmd_wr | WR_RSP_EN;
      done        = (state_q == ST_REQ) & bus.iob_ready;
      done_rsp    = done & (~wr_q | WR_RSP_EN);
      expire      = TMO_EN & (state_q == ST_REQ) & ~bus.iob_ready & (cnt_q == CNT_LAST);

      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      err_pend_d  = err_pend_q;

      if (state_q == ST_REQ) begin
         if (done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (done_rsp) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = wr_q ? '0 : bus.iob_rdata;
            end
         end else if (expire) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
         end else if (TMO_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (err_pend_q) begin
         rsp_valid_d = 1'b1;
         rsp_error_d = 1'b1;
         rsp_rdata_d = '0;
         err_pend_d  = 1'b0;
      end

      if (accept) begin
         if (!cmd_illegal) begin
            state_d = ST_REQ;
            addr_d  = addr_map;
            wdata_d = bus.cmd_wdata;
            wstrb_d = cmd_wstrb;
            wr_d    = bus.cmd_wr;
            cnt_d   = '0;
         end else if (err_rsp_req) begin
            if (rsp_valid_d) begin
               err_pend_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
         err_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
         err_pend_q  <= err_pend_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.iob_valid = (state_q == ST_REQ);
   assign bus.iob_addr  = addr_q;
   assign bus.iob_wdata = wdata_q;
   assign bus.iob_wstrb = wstrb_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_error = rsp_error_q;
   assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_iob_split_bus_bridge.sv
// Bench for iob_split_bus_bridge: a 32-bit instance (WR_RSP=0, TIMEOUT=8) and a
// 64-bit instance (WR_RSP=1, timeout disabled) driven from one vector table.
module tb_iob_split_bus_bridge;

   logic clk = 1'b0;
   logic rst_n;
   logic boot;

   always #5 clk = ~clk;

   iob_split_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
   iob_split_bus_bridge_if #(.ADDR_W(32), .DATA_W(64)) ifb ();

   iob_split_bus_bridge #(.ADDR_W(32), .DATA_W(32), .WR_RSP(0), .TIMEOUT(8)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .boot  (boot),
      .bus   (ifa.slave)
   );

   iob_split_bus_bridge #(.ADDR_W(32), .DATA_W(64), .WR_RSP(1), .TIMEOUT(0)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .boot  (boot),
      .bus   (ifb.slave)
   );

   typedef struct {
      string       name;
      bit          b;      // 0 = 32-bit instance, 1 = 64-bit instance
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          lat;    // REQ cycle on which memory raises iob_ready; 0 = never
      logic [7:0]  strb;
      int          len;    // expected number of iob_valid cycles
      bit          rsp;
      bit          err;
   } vec_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } rsp_t;

   typedef struct packed {
      logic        cmd_ready;
      logic        rsp_valid;
      logic        iob_valid;
      logic [31:0] iob_addr;
      logic [63:0] iob_wdata;
      logic [7:0]  iob_wstrb;
   } snap_t;

   localparam int NV = 19;
   vec_t tbl [NV];
   rsp_t qa [$];
   rsp_t qb [$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef IOB_SPLIT_BRIDGE_REMAP_EN
      return a ^ 32'h8000_0000;  // boot is held at 0
`else
      return a;
`endif
   endfunction

   function automatic snap_t snap(input bit b);
      snap_t s;
      if (b) begin
         s = '{ifb.cmd_ready, ifb.rsp_valid, ifb.iob_valid, ifb.iob_addr, ifb.iob_wdata, ifb.iob_wstrb};
      end else begin
         s = '{ifa.cmd_ready, ifa.rsp_valid, ifa.iob_valid, ifa.iob_addr, {32'h0, ifa.iob_wdata}, {4'h0, ifa.iob_wstrb}};
      end
      return s;
   endfunction

   task automatic drive_cmd(input bit b, input logic v, input vec_t t);
      if (b) begin
         ifb.cmd_valid = v; ifb.cmd_wr = t.wr; ifb.cmd_addr = t.addr;
         ifb.cmd_size = t.size; ifb.cmd_wdata = t.wdata;
      end else begin
         ifa.cmd_valid = v; ifa.cmd_wr = t.wr; ifa.cmd_addr = t.addr;
         ifa.cmd_size = t.size; ifa.cmd_wdata = t.wdata[31:0];
      end
   endtask

   task automatic drive_iob(input bit b, input logic rdy, input logic [63:0] rd);
      if (b) begin
         ifb.iob_ready = rdy; ifb.iob_rdata = rd;
      end else begin
         ifa.iob_ready = rdy; ifa.iob_rdata = rd[31:0];
      end
   endtask

   // Scoreboards: responses are checked in order against what the stimulus pushed.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifa.rsp_valid) begin
            if (qa.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_a unexpected: got rsp rdata %h error %b expected none", ifa.rsp_rdata, ifa.rsp_error);
            end else begin
               rsp_t e;
               e = qa.pop_front();
               chk("sb_a", "rdata", {32'h0, ifa.rsp_rdata}, {32'h0, e.rdata[31:0]});
               chk("sb_a", "error", ifa.rsp_error, e.err);
            end
         end else begin
            chk("sb_a", "error_idle", ifa.rsp_error, 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (ifb.rsp_valid) begin
            if (qb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_b unexpected: got rsp rdata %h error %b expected none", ifb.rsp_rdata, ifb.rsp_error);
            end else begin
               rsp_t e;
               e = qb.pop_front();
               chk("sb_b", "rdata", ifb.rsp_rdata, e.rdata);
               chk("sb_b", "error", ifb.rsp_error, e.err);
            end
         end else begin
            chk("sb_b", "error_idle", ifb.rsp_error, 0);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      snap_t s;
      rsp_t  e;
      int    hi;
      int    nrsp;
      int    rsp_at;
      @(posedge clk); #1;
      drive_cmd(v.b, 1'b1, v);
      #1;
      s = snap(v.b);
      chk(v.name, "cmd_ready", s.cmd_ready, 1);
      if (v.rsp) begin
         e.rdata = (v.err || v.wr) ? 64'h0 : v.rdata;
         e.err   = v.err;
         if (v.b) qb.push_back(e); else qa.push_back(e);
      end
      hi = 0; nrsp = 0; rsp_at = -1;
      for (int c = 0; c < 24; c++) begin
         @(posedge clk); #1;
         if (c == 0) drive_cmd(v.b, 1'b0, v);
         s = snap(v.b);
         if (s.rsp_valid) begin
            nrsp++;
            rsp_at = c;
         end
         if (s.iob_valid) begin
            if (hi == 0) begin
               chk(v.name, "iob_addr", s.iob_addr, exp_addr(v.addr));
               chk(v.name, "iob_wstrb", s.iob_wstrb, v.strb);
               chk(v.name, "iob_wdata", s.iob_wdata, v.b ? v.wdata : {32'h0, v.wdata[31:0]});
            end
            hi++;
            drive_iob(v.b, hi == v.lat, v.rdata);
         end else begin
            drive_iob(v.b, 1'b0, 64'h0);
         end
      end
      chk(v.name, "iob_cycles", hi, v.len);
      chk(v.name, "rsp_count", nrsp, v.rsp ? 1 : 0);
      if (v.rsp) chk(v.name, "rsp_cycle", rsp_at, v.len);
      $display("txn %-12s iob_cycles=%0d rsp_pulses=%0d", v.name, hi, nrsp);
   endtask

   task automatic back_to_back();
      vec_t  t1, t2;
      snap_t s;
      t1 = '{"b2b_1", 1'b0, 1'b0, 32'h10, 2'd2, 64'h0, 64'h0000_0000_1111_2222, 2, 8'h0, 2, 1'b1, 1'b0};
      t2 = '{"b2b_2", 1'b0, 1'b0, 32'h14, 2'd2, 64'h0, 64'h0000_0000_3333_4444, 1, 8'h0, 1, 1'b1, 1'b0};
      @(posedge clk); #1;
      drive_cmd(1'b0, 1'b1, t1);
      qa.push_back('{t1.rdata, 1'b0});
      @(posedge clk); #1;
      drive_cmd(1'b0, 1'b0, t1);
      s = snap(1'b0);
      chk("b2b", "first_valid", s.iob_valid, 1);
      @(posedge clk); #1;
      drive_iob(1'b0, 1'b1, t1.rdata);
      drive_cmd(1'b0, 1'b1, t2);
      qa.push_back('{t2.rdata, 1'b0});
      #1;
      s = snap(1'b0);
      chk("b2b", "ready_on_complete", s.cmd_ready, 1);
      @(posedge clk); #1;
      drive_cmd(1'b0, 1'b0, t2);
      s = snap(1'b0);
      chk("b2b", "second_valid_no_gap", s.iob_valid, 1);
      chk("b2b", "second_addr", s.iob_addr, exp_addr(t2.addr));
      chk("b2b", "first_rsp", s.rsp_valid, 1);
      drive_iob(1'b0, 1'b1, t2.rdata);
      @(posedge clk); #1;
      drive_iob(1'b0, 1'b0, 64'h0);
      s = snap(1'b0);
      chk("b2b", "second_rsp", s.rsp_valid, 1);
      chk("b2b", "idle_after", s.iob_valid, 0);
      $display("txn %-12s two reads back to back", "b2b");
   endtask

   task automatic reset_mid();
      vec_t  t;
      snap_t s;
      t = '{"rst_mid", 1'b0, 1'b0, 32'h20, 2'd2, 64'h0, 64'h0000_0000_9999_8888, 1, 8'h0, 1, 1'b0, 1'b0};
      @(posedge clk); #1;
      drive_cmd(1'b0, 1'b1, t);
      @(posedge clk); #1;
      drive_cmd(1'b0, 1'b0, t);
      drive_iob(1'b0, 1'b1, t.rdata);
      #1;
      s = snap(1'b0);
      chk("rst_mid", "valid_before", s.iob_valid, 1);
      rst_n = 1'b0;
      #1;
      s = snap(1'b0);
      chk("rst_mid", "valid_dropped", s.iob_valid, 0);
      chk("rst_mid", "addr_cleared", s.iob_addr, 0);
      chk("rst_mid", "cmd_ready", s.cmd_ready, 1);
      chk("rst_mid", "rsp_valid", s.rsp_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      drive_iob(1'b0, 1'b0, 64'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         s = snap(1'b0);
         chk("rst_mid", "no_rsp", s.rsp_valid, 0);
         chk("rst_mid", "no_valid", s.iob_valid, 0);
      end
      $display("txn %-12s reset during REQ", "rst_mid");
   endtask

   initial begin
      //            name          b     wr    addr        sz     wdata                   rdata                   lat strb   len rsp   err
      tbl[0]  = '{"rd_w",       1'b0, 1'b0, 32'h100, 2'd2, 64'h0,                  64'hDEAD_BEEF,          3,  8'h00, 3,  1'b1, 1'b0};
      tbl[1]  = '{"wr_b",       1'b0, 1'b1, 32'h103, 2'd0, 64'hAB00_0000,          64'h0,                  1,  8'h08, 1,  1'b0, 1'b0};
      tbl[2]  = '{"wr_h",       1'b0, 1'b1, 32'h102, 2'd1, 64'h1234_0000,          64'h0,                  2,  8'h0C, 2,  1'b0, 1'b0};
      tbl[3]  = '{"rd_h_mis",   1'b0, 1'b0, 32'h101, 2'd1, 64'h0,                  64'h0,                  1,  8'h00, 0,  1'b1, 1'b1};
      tbl[4]  = '{"rd_d_ill",   1'b0, 1'b0, 32'h000, 2'd3, 64'h0,                  64'h0,                  1,  8'h00, 0,  1'b1, 1'b1};
      tbl[5]  = '{"wr_w_mis",   1'b0, 1'b1, 32'h102, 2'd2, 64'h1111_1111,          64'h0,                  1,  8'h00, 0,  1'b0, 1'b0};
      tbl[6]  = '{"rd_tmo",     1'b0, 1'b0, 32'h200, 2'd2, 64'h0,                  64'h77,                 0,  8'h00, 8,  1'b1, 1'b1};
      tbl[7]  = '{"rd_lat8",    1'b0, 1'b0, 32'h204, 2'd2, 64'h0,                  64'h55AA_1234,          8,  8'h00, 8,  1'b1, 1'b0};
      tbl[8]  = '{"rd_remap",   1'b0, 1'b0, 32'h040, 2'd2, 64'h0,                  64'h0BAD_F00D,          1,  8'h00, 1,  1'b1, 1'b0};
      tbl[9]  = '{"wr_b1",      1'b0, 1'b1, 32'h001, 2'd0, 64'h0000_CD00,          64'h0,                  1,  8'h02, 1,  1'b0, 1'b0};
      tbl[10] = '{"rd_b",       1'b0, 1'b0, 32'h003, 2'd0, 64'h0,                  64'h1122_3344,          2,  8'h00, 2,  1'b1, 1'b0};
      tbl[11] = '{"wr_w",       1'b0, 1'b1, 32'h008, 2'd2, 64'hCAFE_BABE,          64'h0,                  1,  8'h0F, 1,  1'b0, 1'b0};
      tbl[12] = '{"b_rd_d",     1'b1, 1'b0, 32'h008, 2'd3, 64'h0,                  64'h0123_4567_89AB_CDEF, 1, 8'h00, 1,  1'b1, 1'b0};
      tbl[13] = '{"b_wr_b",     1'b1, 1'b1, 32'h003, 2'd0, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0,                 2,  8'h08, 2,  1'b1, 1'b0};
      tbl[14] = '{"b_wr_d_mis", 1'b1, 1'b1, 32'h004, 2'd3, 64'h0,                  64'h0,                  1,  8'h00, 0,  1'b1, 1'b1};
      tbl[15] = '{"b_wr_w",     1'b1, 1'b1, 32'h004, 2'd2, 64'hFEED_FACE_FEED_FACE, 64'h0,                 1,  8'hF0, 1,  1'b1, 1'b0};
      tbl[16] = '{"b_rd_long",  1'b1, 1'b0, 32'h010, 2'd2, 64'h0,                  64'hA5A5_0000_0000_5A5A, 15, 8'h00, 15, 1'b1, 1'b0};
      tbl[17] = '{"b_rd_h",     1'b1, 1'b0, 32'h006, 2'd1, 64'h0,                  64'h1234_0000_0000_0000, 1, 8'h00, 1,  1'b1, 1'b0};
      tbl[18] = '{"b_wr_h_mis", 1'b1, 1'b1, 32'h007, 2'd1, 64'h0,                  64'h0,                  1,  8'h00, 0,  1'b1, 1'b1};

      rst_n = 1'b0;
      boot  = 1'b0;
      drive_cmd(1'b0, 1'b0, tbl[0]);
      drive_cmd(1'b1, 1'b0, tbl[0]);
      drive_iob(1'b0, 1'b0, 64'h0);
      drive_iob(1'b1, 1'b0, 64'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset", "a_cmd_ready", ifa.cmd_ready, 1);
      chk("reset", "a_rsp_valid", ifa.rsp_valid, 0);
      chk("reset", "a_rsp_error", ifa.rsp_error, 0);
      chk("reset", "a_rsp_rdata", ifa.rsp_rdata, 0);
      chk("reset", "a_iob_valid", ifa.iob_valid, 0);
      chk("reset", "a_iob_addr", ifa.iob_addr, 0);
      chk("reset", "a_iob_wdata", ifa.iob_wdata, 0);
      chk("reset", "a_iob_wstrb", ifa.iob_wstrb, 0);
      chk("reset", "b_cmd_ready", ifb.cmd_ready, 1);
      chk("reset", "b_iob_valid", ifb.iob_valid, 0);
      chk("reset", "b_rsp_valid", ifb.rsp_valid, 0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(tbl[i]);
      back_to_back();
      reset_mid();

      repeat (3) @(posedge clk);
      #1;
      chk("end", "sb_a_drained", qa.size(), 0);
      chk("end", "sb_b_drained", qb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
